// File: rtl/crypto_result_unload.sv
// Requests a result from the crypto core and streams it as 8 x 32-bit words, LS word first.
// Latency: top_ready one cycle after host_start, first word one cycle after capture; m_tready stalls hold the word.
module crypto_result_unload #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic         unload_clk,
  input  logic         unload_reset,
  input  logic         host_start,
  output logic         top_ready,
  input  logic [254:0] crypto_data_out,
  input  logic         crypto_data_valid,
  output logic [31:0]  m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic         unload_busy,
  output logic         unload_timeout
);

  // One spare bit so the counter can step past the limit without aliasing to zero.
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_CLR, WAIT_RES, SEND} state_t;

  state_t         state, state_nxt;
  logic [255:0]   buffer;
  logic [2:0]     word_idx;
  logic [TW-1:0]  tcnt;
  logic           waiting, expired, handshake, capture;

  assign waiting   = (state == WAIT_CLR) || (state == WAIT_RES);
  assign expired   = waiting && (tcnt == TLIM);
  assign handshake = m_tvalid && m_tready;

  assign top_ready   = (state == REQ);
  assign m_tvalid    = (state == SEND);
  assign m_tlast     = m_tvalid && (word_idx == 3'd7);
  assign m_tdata     = m_tvalid ? buffer[{word_idx, 5'b0} +: 32] : 32'h0;
  assign unload_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:     if (host_start) state_nxt = REQ;
      REQ:      state_nxt = WAIT_CLR;
      // Wait for the core to drop a stale valid before accepting a fresh one.
      WAIT_CLR: begin
        if (expired)                 state_nxt = IDLE;
        else if (!crypto_data_valid) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (expired) begin
          state_nxt = IDLE;
        end else if (crypto_data_valid) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND:     if (handshake && word_idx == 3'd7) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge unload_clk or posedge unload_reset) begin
    if (unload_reset) state <= IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge unload_clk or posedge unload_reset) begin
    if (unload_reset) begin
      buffer         <= '0;
      word_idx       <= '0;
      tcnt           <= '0;
      unload_timeout <= 1'b0;
    end else begin
      if (state == IDLE && host_start) begin
        tcnt           <= '0;
        unload_timeout <= 1'b0;
      end else if (waiting) begin
        tcnt <= tcnt + 1'b1;
      end
      if (expired) unload_timeout <= 1'b1;
      if (capture) begin
        buffer   <= {1'b0, crypto_data_out};
        word_idx <= '0;
      end else if (handshake) begin
        word_idx <= word_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_crypto_result_unload.sv
// Scoreboard bench for crypto_result_unload: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_crypto_result_unload;

  typedef logic [31:0] vec_t [8];

  logic         unload_clk = 1'b0;
  logic         unload_reset;
  logic         host_start;
  logic         top_ready;
  logic [254:0] crypto_data_out;
  logic         crypto_data_valid;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         unload_busy;
  logic         unload_timeout;

  int checks = 0;
  int failures = 0;
  int tr_count = 0;
  int hs_count = 0;
  bit bp = 1'b0;
  logic [32:0] exp_q[$];

  crypto_result_unload #(.TIMEOUT_CYCLES(16)) dut (
    .unload_clk(unload_clk),
    .unload_reset(unload_reset),
    .host_start(host_start),
    .top_ready(top_ready),
    .crypto_data_out(crypto_data_out),
    .crypto_data_valid(crypto_data_valid),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .unload_busy(unload_busy),
    .unload_timeout(unload_timeout)
  );

  always #5 unload_clk = ~unload_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_top_ready"}, top_ready, 0);
    chk({tag, "_m_tvalid"}, m_tvalid, 0);
    chk({tag, "_m_tlast"}, m_tlast, 0);
    chk({tag, "_m_tdata"}, m_tdata, 0);
    chk({tag, "_busy"}, unload_busy, 0);
    chk({tag, "_timeout"}, unload_timeout, 0);
  endtask

  // m_tready pattern 1,0,0,1 while bp is set, otherwise held high
  initial begin
    int k = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge unload_clk);
      #1;
      if (bp) begin
        m_tready = (k == 0 || k == 3);
        k = (k + 1) % 4;
      end else begin
        m_tready = 1'b1;
        k = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stability under stall
  initial begin
    logic [32:0] e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    forever begin
      @(negedge unload_clk);
      if (top_ready) tr_count++;
      if (prev_stall && m_tvalid) begin
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%08h required=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", m_tdata, e[31:0]);
          chk("word_last", m_tlast, e[32]);
        end
        hs_count++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic start_pulse();
    host_start = 1'b1;
    @(posedge unload_clk); #1;
    chk("top_ready_on", top_ready, 1);
    chk("timeout_cleared", unload_timeout, 0);
    host_start = 1'b0;
    @(posedge unload_clk); #1;
    chk("top_ready_off", top_ready, 0);
  endtask

  task automatic pack(input vec_t w, output logic [254:0] d);
    for (int i = 0; i < 7; i++) d[32*i +: 32] = w[i];
    d[254:224] = w[7][30:0];
  endtask

  task automatic push_words(input vec_t w);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, w[i]});
  endtask

  task automatic run(input vec_t w, input int pre, input bit stale, input bit ign);
    logic [254:0] d;
    int tr0;
    int cyc;
    pack(w, d);
    push_words(w);
    tr0 = tr_count;
    start_pulse();
    if (stale) begin
      @(posedge unload_clk); #1;
    end
    crypto_data_valid = 1'b0;
    for (int k = 0; k < pre; k++) begin
      @(posedge unload_clk); #1;
      host_start = ign && (k == 0);
    end
    host_start = 1'b0;
    crypto_data_out = d;
    crypto_data_valid = 1'b1;
    @(posedge unload_clk); #1;
    crypto_data_out = '1;
    cyc = 0;
    while (unload_busy && cyc < 200) begin
      @(posedge unload_clk); #1;
      cyc++;
      host_start = ign && (cyc == 2);
    end
    host_start = 1'b0;
    crypto_data_valid = 1'b0;
    crypto_data_out = '0;
    if (!bp) chk("send_cycles", cyc, 8);
    chk("words_left", exp_q.size(), 0);
    chk("top_ready_pulses", tr_count - tr0, 1);
  endtask

  initial begin
    vec_t v_basic, v_stale, v_bp, v_ign, v_rst, v_post;
    logic [254:0] d;
    bit saw_valid;
    int n;
    int hs0;

    v_basic = '{32'h89ABCDEF, 32'h01234567, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40000000};
    v_stale = '{32'h00005555, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v_bp    = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                32'h55555555, 32'h66666666, 32'h77777777, 32'h7FFFFFFF};
    v_ign   = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678,
                32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000001};
    v_rst   = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                32'hA4A4A4A4, 32'hA5A5A5A5, 32'hA6A6A6A6, 32'h27A7A7A7};
    v_post  = '{32'h13579BDF, 32'h2468ACE0, 32'h0000FFFF, 32'hFFFF0000,
                32'h00000002, 32'h80000000, 32'h76543210, 32'h00C0FFEE};

    unload_reset = 1'b1;
    host_start = 1'b0;
    crypto_data_valid = 1'b0;
    crypto_data_out = '0;
    repeat (3) @(posedge unload_clk);
    #1;
    chk_quiet("in_reset");
    unload_reset = 1'b0;
    repeat (2) @(posedge unload_clk);
    #1;
    chk_quiet("after_reset");

    run(v_basic, 2, 1'b0, 1'b0);

    // stale valid with 0xAAAA present before the request
    crypto_data_out = 255'hAAAA;
    crypto_data_valid = 1'b1;
    repeat (2) @(posedge unload_clk);
    #1;
    run(v_stale, 2, 1'b1, 1'b0);

    bp = 1'b1;
    run(v_bp, 2, 1'b0, 1'b0);
    bp = 1'b0;
    @(posedge unload_clk); #1;

    run(v_ign, 3, 1'b0, 1'b1);

    // timeout: valid never rises
    saw_valid = 1'b0;
    start_pulse();
    repeat (15) begin
      @(posedge unload_clk); #1;
      saw_valid |= m_tvalid;
    end
    chk("busy_before_timeout", unload_busy, 1);
    chk("timeout_early", unload_timeout, 0);
    @(posedge unload_clk); #1;
    chk("timeout_set", unload_timeout, 1);
    chk("busy_after_timeout", unload_busy, 0);
    repeat (3) @(posedge unload_clk);
    #1;
    chk("timeout_sticky", unload_timeout, 1);
    chk("no_tvalid_in_timeout", saw_valid, 0);
    run(v_basic, 2, 1'b0, 1'b0);

    // reset after word 3 accepted
    pack(v_rst, d);
    push_words(v_rst);
    start_pulse();
    @(posedge unload_clk); #1;
    hs0 = hs_count;
    crypto_data_out = d;
    crypto_data_valid = 1'b1;
    n = 0;
    while (hs_count < hs0 + 4 && n < 100) begin
      @(posedge unload_clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL reset_wait_word3 actual=%0d required=%0d", hs_count - hs0, 4);
    end
    unload_reset = 1'b1;
    #1;
    chk_quiet("mid_reset");
    exp_q.delete();
    crypto_data_valid = 1'b0;
    crypto_data_out = '0;
    @(posedge unload_clk); #1;
    unload_reset = 1'b0;
    repeat (3) @(posedge unload_clk);
    #1;
    chk_quiet("post_reset_idle");
    run(v_post, 2, 1'b0, 1'b0);

    repeat (5) @(posedge unload_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
